// File: rtl/mux_bus_ram_pkg.sv
// mux_bus_pkg: shared types and constants for the multiplexed-bus RAM slave.
//
// Contents:
//   bus_state_t  - controller states (IDLE, READ, WRITE)
//   RW_READ      - value of rw that requests a read burst
//   RW_WRITE     - value of rw that requests a write burst
//   blen_width() - width of the burst-length field for a given MAX_BURST
//
// Optional feature macro used elsewhere in this slice: MUX_BUS_RAM_RANGE_CHECK_EN

package mux_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } bus_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // A MAX_BURST of 1 would give a zero-width field; keep one bit so the
    // port still exists and always carries zero.
    function automatic int blen_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/mux_bus_ram_if.sv
// mux_bus_ram_if: request/handshake signals between a bus master (Core)
// and the mux_bus_ram slave. The shared address/data bus itself stays a
// plain inout port on the slave so it can be resolved as a tristate net.
//
// Signals:
//   req   master -> slave  request strobe, sampled only while the slave is idle
//   rw    master -> slave  1 = read, 0 = write, sampled with req
//   blen  master -> slave  beats minus one, sampled with req
//   busy  slave  -> master high whenever the slave is not idle
//   valid slave  -> master high while the slave drives read data
//   err   slave  -> master one-cycle reject pulse (only with
//                          MUX_BUS_RAM_RANGE_CHECK_EN defined)

interface mux_bus_ram_if
    import mux_bus_pkg::*;
#(
    parameter int MAX_BURST = 4
);
    localparam int BLEN_W = blen_width(MAX_BURST);

    logic              req;
    logic              rw;
    logic [BLEN_W-1:0] blen;
    logic              busy;
    logic              valid;
`ifdef MUX_BUS_RAM_RANGE_CHECK_EN
    logic              err;

    modport master (
        output req, rw, blen,
        input  busy, valid, err
    );

    modport slave (
        input  req, rw, blen,
        output busy, valid, err
    );
`else
    modport master (
        output req, rw, blen,
        input  busy, valid
    );

    modport slave (
        input  req, rw, blen,
        output busy, valid
    );
`endif

endinterface

// File: rtl/mux_bus_ram_wrap_addr_ctr.sv
// wrap_addr_ctr: address and beat-count registers for one burst.
//
// On load the start address is reduced modulo DEPTH and the beat count is
// taken from blen. Each step advances the address by one, wrapping from
// DEPTH-1 back to 0 (modulo DEPTH, not modulo the bus width), and counts
// the remaining beats down. Load has priority over step.
//
// Ports:
//   clk      clock, rising edge
//   rst_b    synchronous active-low reset, clears address and count
//   load     capture ld_addr/ld_cnt
//   step     advance address, decrement count
//   ld_addr  start address as carried on the bus (DATA_W bits)
//   ld_cnt   beats minus one
//   addr     current word index (0 .. DEPTH-1)
//   cnt_zero remaining-beat count has reached zero (last beat)

module wrap_addr_ctr #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] ld_addr,
    input  logic [CNT_W-1:0]  ld_cnt,
    output logic [IDX_W-1:0]  addr,
    output logic              cnt_zero
);

    // One extra bit so DEPTH = 2**DATA_W is representable as a divisor.
    localparam logic [DATA_W:0] DEPTH_X = (DATA_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] ld_idx;
    logic [IDX_W-1:0] addr_nxt;

    // The remainder is always below DEPTH, so it fits in IDX_W bits.
    assign ld_idx   = IDX_W'({1'b0, ld_addr} % DEPTH_X);
    assign addr_nxt = (addr_q == LAST) ? '0 : addr_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            addr_q <= ld_idx;
            cnt_q  <= ld_cnt;
        end else if (step) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    assign addr     = addr_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/mux_bus_ram.sv
// mux_bus_ram: single-port RAM slave on a shared, multiplexed, bidirectional
// address/data bus. A request cycle carries the start address on uniBus;
// the following blen+1 cycles carry data, with the word address advancing
// and wrapping modulo DEPTH.
//
// Parameters:
//   DATA_W     bus/word width, also the address width carried on the bus
//   DEPTH      number of words, 2 <= DEPTH <= 2**DATA_W
//   MAX_BURST  maximum beats per request, power of two
//
// Ports:
//   CLK     clock, rising edge
//   RST     synchronous active-low reset (memory contents are kept)
//   bus     mux_bus_ram_if.slave: req, rw, blen in; busy, valid (, err) out
//   uniBus  inout address/data bus, driven only in READ
//
// Config macro MUX_BUS_RAM_RANGE_CHECK_EN:
//   defined   - a start address >= DEPTH is rejected, err pulses one cycle
//   undefined - the start address is reduced modulo DEPTH
//
// state | meaning
// IDLE  | bus released, waiting for req
// READ  | driving mem[addr] on uniBus with valid high, one beat per cycle
// WRITE | writing uniBus into mem[addr] at each edge, one beat per cycle

module mux_bus_ram
    import mux_bus_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    mux_bus_ram_if.slave      bus,
    inout  wire  [DATA_W-1:0] uniBus
);

    localparam int BLEN_W = blen_width(MAX_BURST);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bus_state_t        state_q;
    logic              idle;
    logic              accept;
    logic              step;
    logic [IDX_W-1:0]  addr;
    logic              cnt_zero;
    logic [DATA_W-1:0] mem [DEPTH];

    assign idle = (state_q == IDLE);

`ifdef MUX_BUS_RAM_RANGE_CHECK_EN
    localparam logic [DATA_W:0] DEPTH_X = (DATA_W + 1)'(DEPTH);

    logic in_range;
    logic err_q;

    assign in_range = ({1'b0, uniBus} < DEPTH_X);
    assign accept   = idle && bus.req && in_range;

    // A rejected request leaves the FSM idle; the pulse follows edge N.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= idle && bus.req && !in_range;
        end
    end

    assign bus.err = err_q;
`else
    assign accept = idle && bus.req;
`endif

    // The last beat is the one where the count is already zero; the FSM
    // leaves the burst on that edge and the counter simply holds.
    assign step = !idle && !cnt_zero;

    wrap_addr_ctr #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .CNT_W  (BLEN_W)
    ) u_ctr (
        .clk      (CLK),
        .rst_b    (RST),
        .load     (accept),
        .step     (step),
        .ld_addr  (uniBus),
        .ld_cnt   (bus.blen),
        .addr     (addr),
        .cnt_zero (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= (bus.rw == RW_READ) ? READ : WRITE;
                    end
                end
                READ, WRITE: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // No reset on the array. Reset still gates the write so that a burst
    // aborted by RST drops the beat presented at the reset edge.
    always_ff @(posedge CLK) begin
        if (RST && (state_q == WRITE)) begin
            mem[addr] <= uniBus;
        end
    end

    assign uniBus    = (state_q == READ) ? mem[addr] : 'z;
    assign bus.valid = (state_q == READ);
    assign bus.busy  = !idle;

endmodule

// File: tb/tb_mux_bus_ram.sv
module tb_mux_bus_ram;
    import mux_bus_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 200;
    localparam int MB    = 4;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    // Released bus floats to all ones, so "released" is observable as 8'hFF.
    tri1 [DW-1:0] uni_bus;
    logic          tb_oe = 1'b0;
    logic [DW-1:0] tb_d  = '0;
    assign uni_bus = tb_oe ? tb_d : 'z;

    mux_bus_ram_if #(.MAX_BURST(MB)) bif ();

    mux_bus_ram #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .MAX_BURST (MB)
    ) dut (
        .CLK    (clk),
        .RST    (rst_b),
        .bus    (bif.slave),
        .uniBus (uni_bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wbuf  [4];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One request plus its beats. abort_at: beat index at which RST is pulled
    // low (>= beats means no abort). poke_at: beat index during which a stray
    // req is raised (>= beats means none).
    task automatic burst(input bit rd, input int addr, input int beats,
                         input int abort_at, input int poke_at);
        int a;
        bit aborted;
        aborted = 1'b0;
        @(posedge clk); #1;
        bif.req  = 1'b1;
        bif.rw   = rd ? RW_READ : RW_WRITE;
        bif.blen = 2'(beats - 1);
        tb_oe    = 1'b1;
        tb_d     = DW'(addr);
        @(posedge clk); #1;
        bif.req = 1'b0;
        a = addr % DEPTH;
        if (rd) begin
            tb_oe = 1'b0;
            for (int k = 0; k < beats; k++) exp_q.push_back(model[(a + k) % DEPTH]);
        end
        for (int k = 0; k < beats; k++) begin
            if (k == abort_at) begin
                rst_b   = 1'b0;
                tb_oe   = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (!rd) tb_d = wbuf[k];
            if (k == poke_at) begin
                bif.req  = 1'b1;
                bif.rw   = rd ? RW_WRITE : RW_READ;
                bif.blen = 2'(3);
            end
            @(negedge clk);
            chk("busy", 32'(bif.busy), 1);
            chk("valid", 32'(bif.valid), rd ? 1 : 0);
            if (rd) begin
                if (exp_q.size() == 0) chk("sb_empty", 1, 0);
                else chk("rdata", 32'(uni_bus), 32'(exp_q.pop_front()));
            end
            @(posedge clk); #1;
            bif.req = 1'b0;
            if (!rd) model[(a + k) % DEPTH] = wbuf[k];
        end
        tb_oe = 1'b0;
        if (aborted) begin
            @(posedge clk);
            @(posedge clk); #1;
            rst_b = 1'b1;
        end
        @(negedge clk);
        chk("busy_end", 32'(bif.busy), 0);
        chk("valid_end", 32'(bif.valid), 0);
        chk("bus_released", 32'(uni_bus), 32'hff);
    endtask

    task automatic set_wbuf(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        wbuf[0] = d0;
        wbuf[1] = d1;
        wbuf[2] = d2;
        wbuf[3] = d3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req  = 1'b0;
        bif.rw   = RW_READ;
        bif.blen = '0;

        // Power-up reset.
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_valid", 32'(bif.valid), 0);
        chk("rst_bus", 32'(uni_bus), 32'hff);

        // Preload words 0..3, then reset again: contents must survive.
        set_wbuf(8'h10, 8'h11, 8'h12, 8'h13);
        burst(1'b0, 0, 4, 9, 9);
        @(posedge clk); #1 rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst2_busy", 32'(bif.busy), 0);
        chk("rst2_valid", 32'(bif.valid), 0);
        chk("rst2_bus", 32'(uni_bus), 32'hff);
        @(posedge clk); #1 rst_b = 1'b1;
        burst(1'b1, 0, 4, 9, 9);

        // Single read.
        burst(1'b1, 2, 1, 9, 9);

        // Write burst then read back.
        set_wbuf(8'hAA, 8'hAB, 8'hAC, 8'hAD);
        burst(1'b0, 8'h10, 4, 9, 9);
        burst(1'b1, 8'h10, 4, 9, 9);

        // Wrap at DEPTH-2: lands at 198, 199, 0, 1.
        set_wbuf(8'hE0, 8'hE1, 8'hE2, 8'hE3);
        burst(1'b0, DEPTH - 2, 4, 9, 9);
        burst(1'b1, DEPTH - 2, 4, 9, 9);
        burst(1'b1, 0, 2, 9, 9);

        // Mid-burst reset: beats 2 and 3 are dropped.
        set_wbuf(8'h30, 8'h31, 8'h32, 8'h33);
        burst(1'b0, 8'h20, 4, 9, 9);
        set_wbuf(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        burst(1'b0, 8'h20, 4, 2, 9);
        burst(1'b1, 8'h20, 4, 9, 9);

        // Stray requests during busy bursts are ignored.
        set_wbuf(8'h61, 8'h62, 8'h63, 8'h64);
        burst(1'b0, 8'h40, 2, 9, 0);
        burst(1'b1, 8'h40, 4, 9, 1);

`ifdef MUX_BUS_RAM_RANGE_CHECK_EN
        @(posedge clk); #1;
        bif.req  = 1'b1;
        bif.rw   = RW_WRITE;
        bif.blen = 2'(0);
        tb_oe    = 1'b1;
        tb_d     = 8'hF0;
        @(posedge clk); #1;
        bif.req = 1'b0;
        tb_oe   = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(bif.err), 1);
        chk("err_busy", 32'(bif.busy), 0);
        @(negedge clk);
        chk("err_clear", 32'(bif.err), 0);
        chk("err_busy2", 32'(bif.busy), 0);
        burst(1'b1, 40, 1, 9, 9);
`else
        // 0xF0 reduces to word 40.
        set_wbuf(8'h5A, 8'h00, 8'h00, 8'h00);
        burst(1'b0, 8'hF0, 1, 9, 9);
        burst(1'b1, 40, 1, 9, 9);
`endif

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
